// File: rtl/sum_avg3_divider.sv
// rtl/sum_avg3_divider.sv - bit-serial restoring divider producing sum/DIVISOR with remainder (optional SUM_AVG3_ROUND_EN)
module sum_avg3_divider #(
  parameter int SUM_W   = 10,
  parameter int QUOT_W  = 8,
  parameter int REM_W   = 2,
  parameter int DIVISOR = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SUM_W-1:0]  sum,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [QUOT_W-1:0] avg,
  output logic [REM_W-1:0]  rem,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = (SUM_W > 2) ? $clog2(SUM_W) : 1;
  localparam logic [REM_W+1:0] DIV_L    = (REM_W+2)'(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SUM_W - 1);

  if (DIVISOR <= 0) begin : g_bad_divisor
    $error("sum_avg3_divider: DIVISOR must be a positive constant");
  end
  if ((1 << REM_W) < DIVISOR) begin : g_bad_rem_w
    $error("sum_avg3_divider: REM_W too narrow for DIVISOR");
  end
  if (QUOT_W > SUM_W || SUM_W < 2) begin : g_bad_widths
    $error("sum_avg3_divider: need 2 <= SUM_W and QUOT_W <= SUM_W");
  end

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SUM_W-1:0]  dividend;
  logic [REM_W:0]    prem;
  logic [SUM_W-1:0]  quot;
  logic [CNT_W-1:0]  cnt;

  logic [REM_W+1:0]  trial;
  logic [REM_W+1:0]  diff;
  logic [REM_W:0]    prem_step;
  logic [SUM_W-1:0]  quot_step;
  logic              quot_big;
  logic [QUOT_W-1:0] avg_load;
  logic              ovf_load;

  assign in_ready = (state == IDLE);

  // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits
  always_comb begin
    trial     = {prem, dividend[SUM_W-1]};
    diff      = trial - DIV_L;
    prem_step = trial[REM_W:0];
    quot_step = {quot[SUM_W-2:0], 1'b0};
    if (trial >= DIV_L) begin
      prem_step = diff[REM_W:0];
      quot_step = {quot[SUM_W-2:0], 1'b1};
    end
  end

  // Result formed from the final step: saturate on wide quotients, optionally round half up
  always_comb begin
    quot_big = (quot_step >> QUOT_W) != '0;
    avg_load = quot_big ? '1 : quot_step[QUOT_W-1:0];
    ovf_load = quot_big;
`ifdef SUM_AVG3_ROUND_EN
    if (!quot_big && ({1'b0, prem_step[REM_W-1:0], 1'b0} >= DIV_L)) begin
      if (avg_load == '1) begin
        ovf_load = 1'b1;
      end else begin
        avg_load = avg_load + QUOT_W'(1);
      end
    end
`endif
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      dividend  <= '0;
      prem      <= '0;
      quot      <= '0;
      cnt       <= '0;
      avg       <= '0;
      rem       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dividend <= sum;
            prem     <= '0;
            quot     <= '0;
            cnt      <= CNT_INIT;
          end
        end
        DIV: begin
          dividend <= {dividend[SUM_W-2:0], 1'b0};
          prem     <= prem_step;
          quot     <= quot_step;
          if (cnt == '0) begin
            avg       <= avg_load;
            rem       <= prem_step[REM_W-1:0];
            ovf       <= ovf_load;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_avg3_divider.sv
// tb/tb_sum_avg3_divider.sv - directed bench for sum_avg3_divider (default and DIVISOR=1 instances)
module tb_sum_avg3_divider;

  logic       clock;
  logic       reset;
  logic [9:0] sum;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] avg;
  logic [1:0] rem;
  logic       ovf;
  logic       out_valid;
  logic       out_ready;

  logic [9:0] d1_sum;
  logic       d1_in_valid;
  logic       d1_in_ready;
  logic [7:0] d1_avg;
  logic [1:0] d1_rem;
  logic       d1_ovf;
  logic       d1_out_valid;
  logic       d1_out_ready;

  int total = 0;
  int bad   = 0;
  int n;

`ifdef SUM_AVG3_ROUND_EN
  localparam int AVG_101 = 34;
`else
  localparam int AVG_101 = 33;
`endif

  sum_avg3_divider dut (
    .clock(clock), .reset(reset), .sum(sum), .in_valid(in_valid), .in_ready(in_ready),
    .avg(avg), .rem(rem), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  sum_avg3_divider #(.DIVISOR(1)) dut_d1 (
    .clock(clock), .reset(reset), .sum(d1_sum), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .avg(d1_avg), .rem(d1_rem), .ovf(d1_ovf), .out_valid(d1_out_valid), .out_ready(d1_out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until out_valid rises on the default instance, reporting the count (bounded)
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!out_valid && cycles < 40);
    if (!out_valid) begin
      total++;
      bad++;
      $error("FAIL wait_valid: got timeout expected out_valid");
    end
  endtask

  task automatic run_d1(input logic [9:0] s, input int exp_avg, input int exp_ovf, input string tag);
    int c;
    d1_sum = s;
    d1_in_valid = 1'b1;
    tick();
    d1_in_valid = 1'b0;
    c = 0;
    do begin
      tick();
      c++;
    end while (!d1_out_valid && c < 40);
    chk({tag, "_lat"}, c, 10);
    chk({tag, "_avg"}, d1_avg, exp_avg);
    chk({tag, "_ovf"}, d1_ovf, exp_ovf);
    chk({tag, "_rem"}, d1_rem, 0);
    d1_out_ready = 1'b1;
    tick();
    d1_out_ready = 1'b0;
    chk({tag, "_drain"}, d1_out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; sum = '0; in_valid = 1'b0; out_ready = 1'b0;
    d1_sum = '0; d1_in_valid = 1'b0; d1_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_avg", avg, 0);
    chk("rst_rem", rem, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_d1_in_ready", d1_in_ready, 1);

    // sum=100, exact latency
    sum = 10'd100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_in_ready_low", in_ready, 0);
    repeat (9) tick();
    chk("t1_not_yet", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_avg", avg, 33);
    chk("t1_rem", rem, 1);
    chk("t1_ovf", ovf, 0);
    chk("t1_in_ready_done", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_drain_valid", out_valid, 0);
    chk("t1_drain_ready", in_ready, 1);

    // back-to-back 0 then 765 with out_ready held high
    out_ready = 1'b1;
    sum = 10'd0; in_valid = 1'b1;
    tick();
    sum = 10'd765;
    wait_valid(n);
    chk("t2_lat0", n, 10);
    chk("t2_avg0", avg, 0);
    chk("t2_rem0", rem, 0);
    chk("t2_ovf0", ovf, 0);
    wait_valid(n);
    in_valid = 1'b0;
    chk("t2_spacing", n, 12);
    chk("t2_avg765", avg, 255);
    chk("t2_rem765", rem, 0);
    chk("t2_ovf765", ovf, 0);
    tick();
    out_ready = 1'b0;
    chk("t2_idle", in_ready, 1);

    // sum=101, rounding-dependent
    sum = 10'd101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("t3_avg", avg, AVG_101);
    chk("t3_rem", rem, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // backpressure on sum=600
    sum = 10'd600; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_avg", avg, 200);
      chk("t4_hold_rem", rem, 0);
      chk("t4_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_release_valid", out_valid, 0);
    chk("t4_release_ready", in_ready, 1);

    // reset during the 4th DIV cycle of sum=500
    sum = 10'd500; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_avg", avg, 0);
    sum = 10'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("t5_avg9", avg, 3);
    chk("t5_rem9", rem, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // DIVISOR=1 instance: overflow saturation and plain pass-through
    run_d1(10'd700, 255, 1, "d1_700");
    run_d1(10'd200, 200, 0, "d1_200");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_avg3_divider.md
Name: sum_avg3_divider

Overview:
Consumer end of the registered three-operand 8-bit adder path. Accepts the 10-bit registered sum and produces the integer mean (sum / DIVISOR) plus remainder, using a sequential restoring divider. It is bit-serial, takes one quotient bit per clock, and uses a valid/ready handshake on both sides. Sits directly downstream of the adder stage so the lab datapath ends in an 8-bit average.

Parameters:
SUM_W, 10, width of incoming sum; also the number of divide iterations
QUOT_W, 8, width of avg output
REM_W, 2, width of rem output; must satisfy 2**REM_W >= DIVISOR
DIVISOR, 3, constant divisor; DIVISOR = 0 is a compile-time error ($error in generate)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
sum  input  SUM_W  dividend, sampled on accept
in_valid  input  1  sum is valid
in_ready  output  1  block can accept; high only in IDLE
avg  output  QUOT_W  quotient (saturated to QUOT_W bits)
rem  output  REM_W  remainder, sum mod DIVISOR
ovf  output  1  true quotient exceeded 2**QUOT_W-1; avg saturated
out_valid  output  1  avg/rem/ovf valid
out_ready  input  1  downstream accepts result

Behaviour:
- Reset (reset=1 at rising edge): state=IDLE, out_valid=0, avg=0, rem=0, ovf=0, internal regs cleared. in_ready=1 on the first cycle after reset deasserts. Reset overrides everything, including mid-DIV and DONE-with-stall; any in-flight result is discarded.
- FSM states: IDLE, DIV, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1: capture sum into the dividend register, clear the partial remainder (width REM_W+1) and the quotient register (SUM_W bits), set bit counter = SUM_W-1, go to DIV. Otherwise stay in IDLE.
- DIV: in_ready=0. Each edge performs one restoring step:
  - trial = {prem, dividend MSB}
  - if trial >= DIVISOR: prem = trial - DIVISOR and shift 1 into the quotient; else prem = trial and shift 0 into the quotient
  - dividend shifts left 1
  - When counter = 0 on that edge, go to DONE and load outputs: rem = prem[REM_W-1:0]; if quotient bits above QUOT_W are nonzero, avg = all-ones and ovf = 1, else avg = quotient[QUOT_W-1:0] and ovf = 0.
  - Otherwise decrement the counter.
- DONE: out_valid=1. avg, rem and ovf are held stable while out_ready=0. On an edge with out_ready=1: out_valid goes to 0 and state goes to IDLE. Outputs keep their last values; they are don't-care while out_valid=0.
- Latency: acceptance edge E; out_valid is high in the cycle after edge E+SUM_W (10 cycles by default).
- Throughput: with no stall, one result per SUM_W+2 cycles. No new acceptance occurs in the same cycle as an output handshake.
- in_valid while in DIV or DONE is ignored; the upstream source holds its data per valid/ready rules.
- Default width check: max sum 765 / 3 = 255, so ovf can only assert when DIVISOR < 3.
- All outputs are registered; no combinational path from input to output except in_ready, which is decoded from the state register only.

Optional Feature:
Macro: SUM_AVG3_ROUND_EN
- Defined: on the DONE load edge, if 2*rem >= DIVISOR, avg = quotient + 1, giving round-half-up. The increment saturates at 2**QUOT_W-1 and sets ovf when it saturates. rem still reports the raw truncating remainder. Latency is unchanged.
- Undefined: avg is the truncated quotient; no increment logic is synthesized.

Test Plan:
- Reset, then sum=100, in_valid pulsed 1 cycle -> in_ready falls next cycle; 10 cycles later out_valid=1, avg=33, rem=1, ovf=0.
- sum=0 then sum=765, out_ready held 1 -> avg=0/rem=0, then avg=255/rem=0, ovf=0 both times; results spaced 12 cycles apart.
- sum=101, SUM_AVG3_ROUND_EN undefined -> avg=33, rem=2. Same stimulus with SUM_AVG3_ROUND_EN defined -> avg=34, rem=2.
- Backpressure: sum=600, out_ready=0 for 5 cycles after out_valid -> avg=200 and rem=0 held stable, in_ready stays 0. out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
- Reset asserted on the 4th DIV cycle of sum=500 -> next cycle out_valid=0, in_ready=1, avg=0. A new sum=9 then gives avg=3, rem=0.
- DIVISOR=1 build, sum=700 -> avg=255, ovf=1, rem=0. With DIVISOR=1, sum=200 -> avg=200, ovf=0.
